bit_serializer: RTL and testbench

Parallel-to-serial stage that sits directly upstream of the 1101 sequence detector and drives its 1-bit `in` stream. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, with a one-word holding buffer so consecutive words stream with no idle bits between them. Also provides a serial-valid qualifier and an end-of-word pulse for downstream framing.

---
 rtl/bit_serializer_pkg.sv | 28 ++
 rtl/word_hold_buf.sv | 31 +++
 rtl/bit_serializer.sv | 121 ++++++++++++
 tb/tb_bit_serializer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// No ports. Provides the shifter state enum, the counter-width helper
// and the bit-order select used for MSB-first/LSB-first emission.
package bit_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter width for a WIDTH-bit word; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   // Returns the bit emitted at position idx of a word (idx 0 = first bit out).
   // A shift is used instead of a variable bit-select so the index width
   // never has to match the word width.
   function automatic logic bit_select(input logic [31:0] word,
                                       input int          idx,
                                       input int          width,
                                       input bit          msb_first);
      logic [31:0] shifted;
      shifted = msb_first ? (word >> (width - 1 - idx)) : (word >> idx);
      return shifted[0];
   endfunction

endpackage

// File: rtl/word_hold_buf.sv
// Single-entry holding register with a valid flag.
// Latency: write visible on rd_data/full after the writing edge.
// Backpressure: the owner must not write while full; a read clears full.
// Ports: clk, rst (async high), wr/wr_data (load), rd (drain), rd_data, full.
module word_hold_buf
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic [WIDTH-1:0] rd_data,
   output logic             full
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
         full    <= 1'b0;
      end else if (wr) begin
         rd_data <= wr_data;
         full    <= 1'b1;
      end else if (rd) begin
         full    <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer for gapless streaming.
// Latency: word accepted at edge N shows its first bit after edge N+1, last after N+WIDTH.
// Backpressure: data_ready drops while the holding buffer is occupied.
// Ports: clk, rst (async high); data_in/data_valid/data_ready word input;
//        ser_out/ser_valid serial output, word_done last-bit pulse, busy.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int               CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             last;
   logic             hold_wr;
   logic             hold_rd;
   logic             hold_full;
   logic [WIDTH-1:0] hold_data;
   logic             nxt_busy;
   logic             cur_bit;

   assign data_ready = !hold_full;
   assign accept     = data_valid && data_ready;
   assign last       = (state == SHIFT) && (cnt == LAST);

   // A word arriving on the last bit goes straight into the shifter, so the
   // holding buffer is only written when the shifter is mid-word.
   assign hold_wr    = accept && (state == SHIFT) && !last;
   assign hold_rd    = last && hold_full;

   assign cur_bit    = bit_select(32'(sh), int'(cnt), WIDTH, MSB_FIRST != 0);

   word_hold_buf #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .wr      (hold_wr),
      .wr_data (data_in),
      .rd      (hold_rd),
      .rd_data (hold_data),
      .full    (hold_full)
   );

   // busy is registered, so compute what state/hold_v will be after this edge.
   always_comb begin
      nxt_busy = 1'b0;
      if (hold_wr || (hold_full && !hold_rd)) begin
         nxt_busy = 1'b1;
      end else if (state == IDLE) begin
         nxt_busy = accept;
      end else begin
         nxt_busy = !last || hold_full || accept;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sh        <= '0;
         cnt       <= '0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         word_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         busy <= nxt_busy;
         case (state)
            IDLE: begin
               ser_out   <= 1'b0;
               ser_valid <= 1'b0;
               word_done <= 1'b0;
               cnt       <= '0;
               if (accept) begin
                  sh    <= data_in;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               ser_out   <= cur_bit;
               ser_valid <= 1'b1;
               word_done <= last;
               if (!last) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  cnt <= '0;
                  if (hold_full) begin
                     sh <= hold_data;
                  end else if (accept) begin
                     sh <= data_in;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;

   logic ready_m, sout_m, sval_m, done_m, busy_m;
   logic ready_l, sout_l, sval_l, done_l, busy_l;

   int total  = 0;
   int passed = 0;

   // Reference model: pending bits in emission order, per bit order,
   // plus a flag marking the final bit of each word.
   bit qm[$];
   bit ql[$];
   bit qd[$];

   bit exp_m, exp_l, exp_d, exp_v;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (ready_m),
      .ser_out    (sout_m),
      .ser_valid  (sval_m),
      .word_done  (done_m),
      .busy       (busy_m)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (ready_l),
      .ser_out    (sout_l),
      .ser_valid  (sval_l),
      .word_done  (done_l),
      .busy       (busy_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
      end
   endtask

   task automatic chk_outputs();
      chk("ser_out_msb",   sout_m, exp_m);
      chk("ser_valid_msb", sval_m, exp_v);
      chk("word_done_msb", done_m, exp_d);
      chk("busy_msb",      busy_m, qm.size() > 0);
      chk("ser_out_lsb",   sout_l, exp_l);
      chk("ser_valid_lsb", sval_l, exp_v);
      chk("word_done_lsb", done_l, exp_d);
      chk("busy_lsb",      busy_l, ql.size() > 0);
   endtask

   // One clock cycle: present inputs, check readiness, clock, check outputs.
   task automatic step(input logic v, input logic [7:0] d, output bit acc);
      bit rdy;
      data_valid = v;
      data_in    = d;
      #1;
      // Room exists unless a whole word is already waiting behind the current one.
      rdy = (qm.size() <= 8);
      chk("data_ready_msb", ready_m, rdy);
      chk("data_ready_lsb", ready_l, rdy);
      acc = v && rdy;
      @(posedge clk);
      if (qm.size() > 0) begin
         exp_m = qm.pop_front();
         exp_l = ql.pop_front();
         exp_d = qd.pop_front();
         exp_v = 1'b1;
      end else begin
         exp_m = 1'b0;
         exp_l = 1'b0;
         exp_d = 1'b0;
         exp_v = 1'b0;
      end
      if (acc) begin
         for (int i = 0; i < 8; i++) begin
            qm.push_back(d[7-i]);
            ql.push_back(d[i]);
            qd.push_back(i == 7);
         end
      end
      #1;
      chk_outputs();
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), acc);
   endtask

   // Present words back to back with data_valid held high, waiting for each accept.
   task automatic stream(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input int n);
      logic [7:0] w[3];
      bit acc;
      int guard;
      w[0] = w0; w[1] = w1; w[2] = w2;
      for (int i = 0; i < n; i++) begin
         guard = 0;
         acc   = 1'b0;
         while (!acc && guard < 40) begin
            step(1'b1, w[i], acc);
            guard++;
         end
         if (!acc) chk("accept_timeout", 1'b0, 1'b1);
      end
   endtask

   task automatic clear_model();
      qm.delete();
      ql.delete();
      qd.delete();
      exp_m = 1'b0; exp_l = 1'b0; exp_d = 1'b0; exp_v = 1'b0;
   endtask

   initial begin
      bit acc;
      rst        = 1'b1;
      data_valid = 1'b0;
      data_in    = 8'h00;
      clear_model();
      #1;
      chk_outputs();
      chk("reset_ready_msb", ready_m, 1'b1);
      chk("reset_ready_lsb", ready_l, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single word 0xD0 (LSB instance sees 0xD0 reversed).
      step(1'b1, 8'hD0, acc);
      idle(11);

      // LSB-first pattern 0x0B -> 1,1,0,1,0,0,0,0 on the LSB instance.
      step(1'b1, 8'h0B, acc);
      idle(11);

      // Back to back, then three words under backpressure.
      stream(8'hD0, 8'hDD, 8'h00, 2);
      idle(18);
      stream(8'hD0, 8'hDD, 8'h5A, 3);
      idle(26);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) != 0), 8'($urandom), acc);
      end
      idle(20);

      // Reset mid-word with a word held: D0 shifting, AA held.
      stream(8'hD0, 8'hAA, 8'h00, 2);
      idle(2);
      data_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      clear_model();
      chk("rst_ser_valid", sval_m, 1'b0);
      chk("rst_ser_out",   sout_m, 1'b0);
      chk("rst_ready",     ready_m, 1'b1);
      chk("rst_busy",      busy_m, 1'b0);
      chk("rst_busy_lsb",  busy_l, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 8'hFF, acc);
      idle(11);

      // Idle stability with toggling data.
      idle(20);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
